histogram_run_controller: RTL and testbench

Sequences one code-density measurement run around the histogrammer, its sample FIFO and the dual-port histogram RAM. It clears the RAM, gates ADC sample writes into the FIFO for a programmed sample count, waits for the histogrammer to drain, then streams every RAM bin out through a valid/ready port. It owns RAM port A during the clear phase and RAM port B during readout. It holds the histogrammer in reset outside acquisition.

---
 rtl/histogram_run_controller.sv | 129 ++++++++++++
 tb/tb_histogram_run_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/histogram_run_controller.sv
// histogram_run_controller: sequences clear, acquisition, drain and bin readout for one code-density run.
module histogram_run_controller #(
  parameter int WIDTH_RAM = 16,
  parameter int DEPTH_RAM = 1024,
  parameter int CNT_W = 32,
  parameter int DRAIN_CYC = 4,
  localparam int AW = $clog2(DEPTH_RAM)
) (
  input  logic                 clk100,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     n_samples,
  input  logic                 adc_valid,
  input  logic                 fifo_empty,
  output logic                 acq_en,
  output logic                 hist_rst,
  input  logic                 hist_wen,
  input  logic [AW-1:0]        hist_addr,
  input  logic [WIDTH_RAM-1:0] hist_din,
  output logic                 ram_wen,
  output logic [AW-1:0]        ram_addr_a,
  output logic [WIDTH_RAM-1:0] ram_din_a,
  output logic [AW-1:0]        ram_addr_b,
  input  logic [WIDTH_RAM-1:0] ram_dout_b,
  output logic [WIDTH_RAM-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);
  localparam int DCW = $clog2(DRAIN_CYC + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, ACQUIRE, DRAIN, RD_ADDR, RD_WAIT, PRESENT, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, n_q, n_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [WIDTH_RAM-1:0] data_q, data_d;
  logic acq_en_q, acq_en_d, hist_rst_q, hist_rst_d, busy_q, busy_d;
  logic out_valid_q, out_valid_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    n_d = n_q;
    dcnt_d = '0;
    data_d = data_q;
    case (state_q)
      IDLE: if (start) begin
        n_d = n_samples;
        addr_d = '0;
        cnt_d = '0;
        state_d = CLEAR;
      end
      CLEAR: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == AW'(DEPTH_RAM - 1)) state_d = (n_q != '0) ? ACQUIRE : DRAIN;
      end
      ACQUIRE: if (adc_valid) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == n_q) state_d = DRAIN;
      end
      DRAIN: begin
        dcnt_d = fifo_empty ? dcnt_q + 1'b1 : '0;
        if (dcnt_d == DCW'(DRAIN_CYC)) begin
          state_d = RD_ADDR;
          addr_d = '0;
        end
      end
      RD_ADDR: state_d = RD_WAIT;
      RD_WAIT: begin
        data_d = ram_dout_b;
        state_d = PRESENT;
      end
      PRESENT: if (out_ready) begin
        if (addr_q == AW'(DEPTH_RAM - 1)) state_d = DONE;
        else begin
          addr_d = addr_q + 1'b1;
          state_d = RD_ADDR;
        end
      end
      DONE: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
    acq_en_d = state_d == ACQUIRE;
    hist_rst_d = !(state_d == ACQUIRE || state_d == DRAIN);
    busy_d = state_d != IDLE;
    out_valid_d = state_d == PRESENT;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      n_q <= '0;
      dcnt_q <= '0;
      data_q <= '0;
      acq_en_q <= 1'b0;
      hist_rst_q <= 1'b1;
      busy_q <= 1'b0;
      out_valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      dcnt_q <= dcnt_d;
      data_q <= data_d;
      acq_en_q <= acq_en_d;
      hist_rst_q <= hist_rst_d;
      busy_q <= busy_d;
      out_valid_q <= out_valid_d;
      done_q <= done_d;
    end
  end
  // Port A belongs to the controller only while clearing; otherwise the histogrammer owns it.
  assign ram_wen = (state_q == CLEAR) ? 1'b1 : hist_wen & ~hist_rst_q;
  assign ram_addr_a = (state_q == CLEAR) ? addr_q : hist_addr;
  assign ram_din_a = (state_q == CLEAR) ? '0 : hist_din;
  assign ram_addr_b = addr_q;
  assign out_data = data_q;
  assign out_valid = out_valid_q;
  assign acq_en = acq_en_q;
  assign hist_rst = hist_rst_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_histogram_run_controller.sv
// tb_histogram_run_controller: directed runs against a FIFO/histogrammer/RAM model with a readout scoreboard.
module tb_histogram_run_controller;
  localparam int DEPTH = 1024;
  logic clk100 = 0, rst = 1, start = 0, abort = 0, adc_valid = 0, fifo_empty_m = 1, hold_full = 0;
  logic [31:0] n_samples = 0;
  logic [9:0] adc_code = 0, hist_addr = 0, ram_addr_a, ram_addr_b;
  logic [15:0] hist_din = 0, ram_din_a, ram_dout_b = 0, out_data;
  logic hist_wen = 0, acq_en, hist_rst, ram_wen, out_valid, out_ready = 1, busy, done, fifo_empty;
  logic [15:0] mem [DEPTH];
  logic [9:0] fifo [$];
  logic [15:0] exp_q [$];
  int exp_hist [DEPTH];
  int nwr = 0, errors = 0, checks = 0;
  assign fifo_empty = fifo_empty_m & ~hold_full;
  always #5 clk100 = ~clk100;
  histogram_run_controller dut (
    .clk100(clk100), .rst(rst), .start(start), .abort(abort), .n_samples(n_samples),
    .adc_valid(adc_valid), .fifo_empty(fifo_empty), .acq_en(acq_en), .hist_rst(hist_rst),
    .hist_wen(hist_wen), .hist_addr(hist_addr), .hist_din(hist_din), .ram_wen(ram_wen),
    .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a), .ram_addr_b(ram_addr_b),
    .ram_dout_b(ram_dout_b), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );
  // RAM, sample FIFO and a one-update-per-two-cycles histogrammer, so each read sees the prior write.
  always @(posedge clk100) begin
    logic [9:0] c;
    ram_dout_b <= mem[ram_addr_b];
    if (ram_wen) mem[ram_addr_a] <= ram_din_a;
    hist_wen <= 1'b0;
    if (hist_rst) fifo.delete();
    else if (!hist_wen && fifo.size() > 0) begin
      c = fifo.pop_front();
      hist_wen <= 1'b1;
      hist_addr <= c;
      hist_din <= mem[c] + 16'd1;
    end
    if (adc_valid && acq_en) begin
      fifo.push_back(adc_code);
      nwr++;
    end
    fifo_empty_m <= fifo.size() == 0;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_start(input int n);
    foreach (exp_hist[i]) exp_hist[i] = 0;
    @(negedge clk100);
    n_samples = n;
    start = 1;
    @(negedge clk100);
    start = 0;
    chk("start_busy", busy, 1);
    chk("start_clear_wen", {ram_wen, ram_addr_a}, {1'b1, 10'd0});
  endtask
  task automatic wait_acq();
    int k = 0;
    while (!acq_en && k < 2000) begin
      @(negedge clk100);
      k++;
    end
    chk("acq_reached", acq_en, 1);
  endtask
  task automatic feed(input int n, input int gap, input bit rnd);
    for (int i = 0; i < n; i++) begin
      adc_code = rnd ? 10'($urandom_range(0, DEPTH - 1)) : 10'(i);
      exp_hist[adc_code]++;
      adc_valid = 1;
      @(negedge clk100);
      adc_valid = 0;
      repeat (gap - 1) @(negedge clk100);
    end
  endtask
  task automatic push_exp();
    foreach (exp_hist[i]) exp_q.push_back(16'(exp_hist[i]));
  endtask
  task automatic finish_run(input bit bp, input bit no_acq);
    int w = 0, dn = 0, cyc = 0;
    bit held = 0, acq = 0;
    logic [15:0] hd = 0, e;
    while (dn == 0 && cyc < 30000) begin
      @(negedge clk100);
      cyc++;
      if (acq_en) acq = 1;
      if (held) chk("hold_stable", {out_valid, out_data}, {1'b1, hd});
      if (done) dn++;
      if (out_valid) begin
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) begin
          chk("queue_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("bin_word", out_data, e);
          end
          w++;
        end
      end
      held = out_valid && !out_ready;
      hd = out_data;
    end
    out_ready = 1;
    chk("done_seen", dn, 1);
    chk("word_count", w, DEPTH);
    chk("scoreboard_empty", exp_q.size(), 0);
    if (no_acq) chk("acq_never", acq, 0);
    @(negedge clk100);
    chk("after_done", {busy, done}, 2'b00);
  endtask
  initial begin
    int base, k;
    bit dseen;
    repeat (3) @(negedge clk100);
    chk("rst_ctrl", {busy, done, acq_en, hist_rst, ram_wen, out_valid}, 6'b000100);
    chk("rst_data", {out_data, ram_addr_b}, 26'd0);
    rst = 0;
    @(negedge clk100);
    start = 1;
    abort = 1;
    @(negedge clk100);
    start = 0;
    abort = 0;
    chk("start_abort_idle", {busy, ram_wen}, 2'b00);
    do_start(1024);
    repeat (10) @(negedge clk100);
    rst = 1;
    @(negedge clk100);
    rst = 0;
    chk("midrun_rst", {busy, done, acq_en, hist_rst, ram_wen, out_valid}, 6'b000100);
    chk("midrun_rst_addr", ram_addr_b, 0);
    for (int r = 0; r < 2; r++) begin
      do_start(1024);
      wait_acq();
      feed(1024, 3, 0);
      push_exp();
      finish_run(0, 0);
    end
    do_start(0);
    push_exp();
    finish_run(0, 1);
    do_start(300);
    wait_acq();
    feed(300, 2, 1);
    push_exp();
    finish_run(1, 0);
    do_start(1024);
    wait_acq();
    base = nwr;
    feed(100, 2, 1);
    abort = 1;
    @(negedge clk100);
    abort = 0;
    chk("abort_state", {acq_en, busy, out_valid, hist_rst}, 4'b0001);
    chk("abort_writes", nwr - base, 100);
    dseen = 0;
    repeat (10) begin
      @(negedge clk100);
      if (done) dseen = 1;
    end
    chk("abort_no_done", {dseen, busy}, 2'b00);
    hold_full = 1;
    do_start(5);
    wait_acq();
    base = nwr;
    adc_code = 7;
    adc_valid = 1;
    repeat (20) @(negedge clk100);
    adc_valid = 0;
    exp_hist[7] = 5;
    push_exp();
    chk("exact_writes", nwr - base, 5);
    repeat (20) @(negedge clk100);
    chk("drain_held", hist_rst, 0);
    hold_full = 0;
    repeat (3) @(negedge clk100);
    hold_full = 1;
    chk("drain_short_run", hist_rst, 0);
    @(negedge clk100);
    hold_full = 0;
    k = 0;
    while (!hist_rst && k < 20) begin
      @(negedge clk100);
      k++;
    end
    chk("drain_cycles", k, 4);
    finish_run(0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
